arbitro_botoes: RTL

ARBITRO_BOTOES -- requirements
Module: arbitro_botoes

---
 rtl/arbitro_botoes.sv | 127 ++++++++++++
 1 files changed

// File: rtl/arbitro_botoes.sv
// Button event arbiter: short/long press requests, round-robin grant into an event FIFO.
// Optional long-press support is enabled by defining ARBITRO_BOTOES_LONGPRESS_EN.
module arbitro_botoes #(
  parameter int N_BTN       = 3,
  parameter int HOLD_CYCLES = 1000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] b_pulse,
  input  logic [N_BTN-1:0] b_hold,
  output logic             evt_valid,
  output logic [2:0]       evt_code,
  input  logic             evt_ready,
  output logic [7:0]       drop_cnt
);

  localparam int NREQ = 2 * N_BTN;
  localparam int IW   = $clog2(NREQ);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  logic [NREQ-1:0]  pending, pending_nxt, set_vec, clr_vec, drop_vec;
  logic [N_BTN-1:0] long_trig;
  logic [IW-1:0]    last_grant, grant_idx;
  logic             grant, found, push_ok, pop;
  logic [2:0]       push_code;
  logic [3:0]       n_drop;
  logic [7:0]       drop_nxt;

  logic [2:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

`ifdef ARBITRO_BOTOES_LONGPRESS_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hold_cnt [N_BTN];

  // Counter saturates, so the trigger compare fires once per hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_BTN; k++) hold_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_BTN; k++) begin
        if (!b_hold[k])                          hold_cnt[k] <= '0;
        else if (hold_cnt[k] != HW'(HOLD_CYCLES)) hold_cnt[k] <= hold_cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_BTN; k++)
      long_trig[k] = b_hold[k] && (hold_cnt[k] == HW'(HOLD_CYCLES - 1));
  end
`else
  logic unused_hold;
  assign unused_hold = ^{b_hold, HOLD_CYCLES != 0};
  assign long_trig   = '0;
`endif

  assign evt_valid = (count != '0);
  assign evt_code  = fifo_mem[rd_ptr];
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = (count < CW'(FIFO_DEPTH)) || pop;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    int idx;
    int gi;
    idx       = 0;
    gi        = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant) + off) % NREQ;
      if (!found && pending[idx]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    grant     = found && push_ok;
    gi        = int'(grant_idx);
    push_code = (gi >= N_BTN) ? {1'b1, 2'(gi - N_BTN)} : {1'b0, 2'(gi)};
  end

  // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    set_vec     = {long_trig, b_pulse};
    clr_vec     = grant ? (NREQ'(1) << grant_idx) : '0;
    drop_vec    = set_vec & pending & ~clr_vec;
    pending_nxt = (pending & ~clr_vec) | set_vec;
    n_drop      = '0;
    for (int i = 0; i < NREQ; i++) n_drop = n_drop + 4'(drop_vec[i]);
    drop_nxt    = ({1'b0, drop_cnt} + 9'(n_drop) > 9'd255) ? 8'hFF : drop_cnt + 8'(n_drop);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      last_grant <= IW'(NREQ - 1);
      drop_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      pending  <= pending_nxt;
      drop_cnt <= drop_nxt;
      if (grant) begin
        last_grant <= grant_idx;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates its visibility, keeping the array a plain RAM.
  always_ff @(posedge clk) begin
    if (grant) fifo_mem[wr_ptr] <= push_code;
  end

endmodule
